// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Brief    : Parity modes, receiver state encoding and baud divider helper.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } rx_state_t;

    // Rounded clock divider giving one oversample tick per call result.
    function automatic int calc_div(input int f_clk, input int baud, input int ovs);
        int den;
        den = baud * ovs;
        return (f_clk + den / 2) / den;
    endfunction

endpackage
`default_nettype wire

// File: rtl/urxd_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : urxd_tick_gen
// Brief    : Oversample prescaler; one-clk o_ce every DIV clocks, clearable.
// Revision : 1.0
// ============================================================================
module urxd_tick_gen #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_ce
);

    localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_ce;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
            r_ce  <= 1'b0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
            r_ce  <= 1'b1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
            r_ce  <= 1'b0;
        end
    end

    assign o_ce = r_ce;

endmodule
`default_nettype wire

// File: rtl/urxd_nb_rx.sv
`default_nettype none
// ============================================================================
// Module   : urxd_nb_rx
// Brief    : Parametrised UART receiver, 3-sample majority vote, parity/framing flags.
// Revision : 1.0
// ============================================================================
module urxd_nb_rx
    import uart_pkg::*;
#(
    parameter int F_CLK  = 50_000_000,
    parameter int BAUD   = 115_200,
    parameter int NB     = 8,
    parameter int PARITY = 0,
    parameter int NSTOP  = 1,
    parameter int OVS    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          URXD,
    input  logic          en_rx,
    output logic [NB-1:0] rx_dat,
    output logic          ok_rx_byte,
    output logic          err_par,
    output logic          err_frame,
    output logic          start_rx,
    output logic [3:0]    cb_bit,
    output logic          ce_tact,
    output logic          ce_bit,
    output logic          T_start,
    output logic          T_dat,
    output logic          T_par,
    output logic          T_stop
);

    localparam int         DIV         = calc_div(F_CLK, BAUD, OVS);
    localparam logic       c_PAR_EN    = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
    localparam logic       c_PAR_ODD   = (PARITY == PAR_ODD);
    localparam logic [3:0] c_TICK_S0   = 4'(OVS / 2 - 1);
    localparam logic [3:0] c_TICK_S1   = 4'(OVS / 2);
    localparam logic [3:0] c_TICK_S2   = 4'(OVS / 2 + 1);
    localparam logic [3:0] c_TICK_LAST = 4'(OVS - 1);
    localparam logic [3:0] c_LAST_DATA = 4'(NB - 1);
    localparam logic [3:0] c_LAST_STOP = 4'(NB + ((PARITY != PAR_NONE) ? 1 : 0) + NSTOP - 1);

    rx_state_t     r_state;
    rx_state_t     w_state_nxt;
    logic [2:0]    r_sync;
    logic [3:0]    r_tick;
    logic          r_s0;
    logic          r_s1;
    logic [NB-1:0] r_shift;
    logic [3:0]    r_cb;
    logic          r_par_pend;
    logic          r_frm_pend;
    logic [NB-1:0] r_dat;
    logic          r_err_par;
    logic          r_err_frm;
    logic          r_ok;

    logic          w_rxd;
    logic          w_fall;
    logic          w_ce_tact;
    logic          w_bit_ce;
    logic          w_vote;
    logic          w_tick_clr;
    logic [NB-1:0] w_shift_nxt;
    logic [3:0]    w_cb_nxt;
    logic          w_par_pend_nxt;
    logic          w_frm_pend_nxt;
    logic [NB-1:0] w_dat_nxt;
    logic          w_err_par_nxt;
    logic          w_err_frm_nxt;
    logic          w_ok_nxt;

    assign w_rxd    = r_sync[1];
    assign w_fall   = r_sync[2] & ~r_sync[1];
    assign w_bit_ce = w_ce_tact && (r_tick == c_TICK_S2);
    assign w_vote   = (r_s0 & r_s1) | (r_s0 & w_rxd) | (r_s1 & w_rxd);

    urxd_tick_gen #(
        .DIV   (DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_tick_clr),
        .o_ce  (w_ce_tact)
    );

    // A held-low line never produces a falling edge, so a break cannot retrigger frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 3'b111;
        end else begin
            r_sync <= {r_sync[1:0], URXD};
        end
    end

    // Tick index restarts at 1 so that index 0 lands on each bit boundary.
    always_ff @(posedge clk) begin
        if (rst || w_tick_clr) begin
            r_tick <= 4'd1;
            r_s0   <= 1'b1;
            r_s1   <= 1'b1;
        end else if (w_ce_tact) begin
            r_tick <= (r_tick == c_TICK_LAST) ? 4'd0 : r_tick + 4'd1;
            if (r_tick == c_TICK_S0) r_s0 <= w_rxd;
            if (r_tick == c_TICK_S1) r_s1 <= w_rxd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_cb       <= 4'd0;
            r_par_pend <= 1'b0;
            r_frm_pend <= 1'b0;
            r_dat      <= '0;
            r_err_par  <= 1'b0;
            r_err_frm  <= 1'b0;
            r_ok       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_cb       <= w_cb_nxt;
            r_par_pend <= w_par_pend_nxt;
            r_frm_pend <= w_frm_pend_nxt;
            r_dat      <= w_dat_nxt;
            r_err_par  <= w_err_par_nxt;
            r_err_frm  <= w_err_frm_nxt;
            r_ok       <= w_ok_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_cb_nxt       = r_cb;
        w_par_pend_nxt = r_par_pend;
        w_frm_pend_nxt = r_frm_pend;
        w_dat_nxt      = r_dat;
        w_err_par_nxt  = r_err_par;
        w_err_frm_nxt  = r_err_frm;
        w_ok_nxt       = 1'b0;
        w_tick_clr     = 1'b0;
        if (!en_rx) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        w_state_nxt = ST_START;
                        w_tick_clr  = 1'b1;
                        w_cb_nxt    = 4'd0;
                    end
                end
                ST_START: begin
                    if (w_bit_ce) begin
                        if (w_vote) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt    = ST_DATA;
                            w_cb_nxt       = 4'd0;
                            w_par_pend_nxt = 1'b0;
                            w_frm_pend_nxt = 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_bit_ce) begin
                        w_shift_nxt = {w_vote, r_shift[NB-1:1]};
                        w_cb_nxt    = r_cb + 4'd1;
                        if (r_cb == c_LAST_DATA) begin
                            w_state_nxt = c_PAR_EN ? ST_PAR : ST_STOP;
                        end
                    end
                end
                ST_PAR: begin
                    if (w_bit_ce) begin
                        w_par_pend_nxt = (^r_shift) ^ w_vote ^ c_PAR_ODD;
                        w_cb_nxt       = r_cb + 4'd1;
                        w_state_nxt    = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_bit_ce) begin
                        w_cb_nxt       = r_cb + 4'd1;
                        w_frm_pend_nxt = r_frm_pend | ~w_vote;
                        if (r_cb == c_LAST_STOP) begin
                            w_dat_nxt     = r_shift;
                            w_err_par_nxt = r_par_pend;
                            w_err_frm_nxt = r_frm_pend | ~w_vote;
                            w_ok_nxt      = 1'b1;
                            if (w_fall) begin
                                w_state_nxt = ST_START;
                                w_tick_clr  = 1'b1;
                                w_cb_nxt    = 4'd0;
                            end else begin
                                w_state_nxt = ST_IDLE;
                            end
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign rx_dat     = r_dat;
    assign ok_rx_byte = r_ok;
    assign err_par    = r_err_par;
    assign err_frame  = r_err_frm;
    assign start_rx   = (r_state != ST_IDLE);
    assign cb_bit     = r_cb;
    assign ce_tact    = w_ce_tact;
    assign ce_bit     = w_bit_ce && (r_state != ST_IDLE);
    assign T_start    = (r_state == ST_START);
    assign T_dat      = (r_state == ST_DATA);
    assign T_par      = (r_state == ST_PAR);
    assign T_stop     = (r_state == ST_STOP);

endmodule
`default_nettype wire

// File: tb/tb_urxd_nb_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_urxd_nb_rx
// Brief    : Scoreboard bench for three receiver configurations sharing one clock.
// Revision : 1.0
// ============================================================================
module tb_urxd_nb_rx;

    localparam int F_CLK = 50_000_000;
    localparam int BAUD  = 781_250;   // divider 4, 64 clocks per bit
    localparam int HALF  = 10;
    localparam int BT    = 1280;

    typedef struct packed {
        logic [8:0] dat;
        logic       par;
        logic       frm;
    } exp_t;

    logic clk = 1'b0;
    always #HALF clk = ~clk;

    logic       rst, rst_c;
    logic       rxd_a, rxd_b, rxd_c;
    logic       en_a, en_b, en_c;
    logic [7:0] dat_a, dat_b;
    logic [6:0] dat_c;
    logic       ok_a, ok_b, ok_c, par_a, par_b, par_c, frm_a, frm_b, frm_c;
    logic       start_a, start_b, start_c;
    logic [3:0] cb_a, cb_b, cb_c;
    logic       tact_a, tact_b, tact_c, bit_a, bit_b, bit_c;
    logic       ts_a, td_a, tp_a, tst_a, ts_b, td_b, tp_b, tst_b, ts_c, td_c, tp_c, tst_c;

    urxd_nb_rx #(.F_CLK(F_CLK), .BAUD(BAUD), .NB(8), .PARITY(0), .NSTOP(1), .OVS(16)) u_a (
        .clk(clk), .rst(rst), .URXD(rxd_a), .en_rx(en_a), .rx_dat(dat_a), .ok_rx_byte(ok_a),
        .err_par(par_a), .err_frame(frm_a), .start_rx(start_a), .cb_bit(cb_a), .ce_tact(tact_a),
        .ce_bit(bit_a), .T_start(ts_a), .T_dat(td_a), .T_par(tp_a), .T_stop(tst_a));

    urxd_nb_rx #(.F_CLK(F_CLK), .BAUD(BAUD), .NB(8), .PARITY(1), .NSTOP(1), .OVS(16)) u_b (
        .clk(clk), .rst(rst), .URXD(rxd_b), .en_rx(en_b), .rx_dat(dat_b), .ok_rx_byte(ok_b),
        .err_par(par_b), .err_frame(frm_b), .start_rx(start_b), .cb_bit(cb_b), .ce_tact(tact_b),
        .ce_bit(bit_b), .T_start(ts_b), .T_dat(td_b), .T_par(tp_b), .T_stop(tst_b));

    urxd_nb_rx #(.F_CLK(F_CLK), .BAUD(BAUD), .NB(7), .PARITY(2), .NSTOP(2), .OVS(16)) u_c (
        .clk(clk), .rst(rst_c), .URXD(rxd_c), .en_rx(en_c), .rx_dat(dat_c), .ok_rx_byte(ok_c),
        .err_par(par_c), .err_frame(frm_c), .start_rx(start_c), .cb_bit(cb_c), .ce_tact(tact_c),
        .ce_bit(bit_c), .T_start(ts_c), .T_dat(td_c), .T_par(tp_c), .T_stop(tst_c));

    exp_t q_a[$], q_b[$], q_c[$];
    int   total = 0;
    int   bad   = 0;
    logic seen8_a = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [8:0] d, input logic p, input logic f);
        exp_t e;
        e.dat = d;
        e.par = p;
        e.frm = f;
        return e;
    endfunction

    // Frame bit vectors, LSB = start bit, transmitted first.
    function automatic logic [15:0] fr8(input logic [7:0] d, input logic s);
        return {6'b0, s, d, 1'b0};
    endfunction
    function automatic logic [15:0] fr8p(input logic [7:0] d, input logic p);
        return {5'b0, 1'b1, p, d, 1'b0};
    endfunction
    function automatic logic [15:0] fr7p2(input logic [6:0] d, input logic p);
        return {5'b0, 2'b11, p, d, 1'b0};
    endfunction

    task automatic drive(input int ch, input logic v);
        case (ch)
            0:       rxd_a = v;
            1:       rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    task automatic tx(input int ch, input logic [15:0] bits, input int n, input int bt);
        for (int i = 0; i < n; i++) begin
            drive(ch, bits[i]);
            #(bt);
        end
    endtask

    always @(negedge clk) begin
        if (tst_a && cb_a == 4'd8) seen8_a = 1'b1;
    end

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (ok_a === 1'b1) begin
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected_ok actual=pulse dat=%0h required=no pulse", dat_a);
            end else begin
                e = q_a.pop_front();
                chk("a_dat", 32'(dat_a), 32'(e.dat[7:0]));
                chk("a_err_par", 32'(par_a), 32'(e.par));
                chk("a_err_frame", 32'(frm_a), 32'(e.frm));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (ok_b === 1'b1) begin
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected_ok actual=pulse dat=%0h required=no pulse", dat_b);
            end else begin
                e = q_b.pop_front();
                chk("b_dat", 32'(dat_b), 32'(e.dat[7:0]));
                chk("b_err_par", 32'(par_b), 32'(e.par));
                chk("b_err_frame", 32'(frm_b), 32'(e.frm));
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (ok_c === 1'b1) begin
            if (q_c.size() == 0) begin
                total++; bad++;
                $display("FAIL c_unexpected_ok actual=pulse dat=%0h required=no pulse", dat_c);
            end else begin
                e = q_c.pop_front();
                chk("c_dat", 32'(dat_c), 32'(e.dat[6:0]));
                chk("c_err_par", 32'(par_c), 32'(e.par));
                chk("c_err_frame", 32'(frm_c), 32'(e.frm));
            end
        end
    end

    initial begin : watchdog
        #(100_000 * 2 * HALF);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rst_c = 1'b1;
        rxd_a = 1'b1; rxd_b = 1'b1; rxd_c = 1'b1;
        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_dat", 32'(dat_a), 32'h0);
        chk("rst_ok", 32'(ok_a), 32'h0);
        chk("rst_flags", 32'({par_a, frm_a}), 32'h0);
        chk("rst_start_rx", 32'(start_a), 32'h0);
        chk("rst_cb_bit", 32'(cb_a), 32'h0);
        chk("rst_strobes", 32'({tact_a, bit_a}), 32'h0);
        chk("rst_t_flags", 32'({ts_a, td_a, tp_a, tst_a}), 32'h0);
        rst = 1'b0; rst_c = 1'b0;
        #(2 * BT);

        fork
            begin : seq_a
                logic [7:0]  tbl [16];
                logic [15:0] f;
                int          spd [2];
                tbl = '{8'h3C, 8'hA5, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h55, 8'hAA,
                        8'h01, 8'h80, 8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h99, 8'h66};
                spd = '{1318, 1242};
                // Basic 8N1 frame.
                q_a.push_back(mk(9'h042, 1'b0, 1'b0));
                tx(0, fr8(8'h42, 1'b1), 10, BT);
                #(2 * BT);
                chk("a_cb_bit_reached_8", 32'(seen8_a), 32'h1);
                // Short low glitch on idle line.
                drive(0, 1'b0);
                #200;
                drive(0, 1'b1);
                repeat (5) @(negedge clk);
                chk("glitch_start_rx_high", 32'(start_a), 32'h1);
                #(2 * BT);
                chk("glitch_back_idle", 32'(start_a), 32'h0);
                chk("glitch_dat_held", 32'(dat_a), 32'h42);
                chk("glitch_flags_held", 32'({par_a, frm_a}), 32'h0);
                // Stop bit forced low, line then held low.
                q_a.push_back(mk(9'h0A5, 1'b0, 1'b1));
                tx(0, fr8(8'hA5, 1'b0), 10, BT);
                #(20 * BT);
                drive(0, 1'b1);
                #(2 * BT);
                chk("a_frame_err_drained", 32'(q_a.size()), 32'h0);
                chk("a_idle_after_low", 32'(start_a), 32'h0);
                // Pure break from idle.
                q_a.push_back(mk(9'h000, 1'b0, 1'b1));
                drive(0, 1'b0);
                #(20 * BT);
                drive(0, 1'b1);
                #(2 * BT);
                chk("break_drained", 32'(q_a.size()), 32'h0);
                chk("break_err_frame_held", 32'(frm_a), 32'h1);
                // Baud mismatch, back-to-back frames.
                for (int s = 0; s < 2; s++) begin
                    for (int i = 0; i < 16; i++) begin
                        q_a.push_back(mk({1'b0, tbl[i]}, 1'b0, 1'b0));
                        tx(0, fr8(tbl[i], 1'b1), 10, spd[s]);
                    end
                end
                #(2 * BT);
                chk("tol_drained", 32'(q_a.size()), 32'h0);
                // Receive enable dropped mid-frame.
                f = fr8(8'h3C, 1'b1);
                tx(0, f, 4, BT);
                @(negedge clk);
                en_a = 1'b0;
                @(negedge clk);
                @(negedge clk);
                chk("en_drop_idle", 32'(start_a), 32'h0);
                chk("en_drop_dat_held", 32'(dat_a), 32'h66);
                chk("en_drop_flags_held", 32'({par_a, frm_a}), 32'h0);
                tx(0, f >> 4, 6, BT);
                #(BT);
                en_a = 1'b1;
                #(BT);
                q_a.push_back(mk(9'h081, 1'b0, 1'b0));
                tx(0, fr8(8'h81, 1'b1), 10, BT);
                #(2 * BT);
            end
            begin : seq_b
                q_b.push_back(mk(9'h042, 1'b1, 1'b0));
                tx(1, fr8p(8'h42, 1'b1), 11, BT);
                q_b.push_back(mk(9'h043, 1'b0, 1'b0));
                tx(1, fr8p(8'h43, 1'b1), 11, BT);
                #(2 * BT);
                chk("b_drained", 32'(q_b.size()), 32'h0);
            end
            begin : seq_c
                bit found;
                q_c.push_back(mk(9'h055, 1'b0, 1'b0));
                tx(2, fr7p2(7'h55, 1'b1), 11, BT);
                #(BT);
                chk("c_first_drained", 32'(q_c.size()), 32'h0);
                found = 1'b0;
                fork
                    tx(2, fr7p2(7'h78, 1'b1), 11, BT);
                    begin
                        for (int k = 0; k < 3000 && !found; k++) begin
                            @(negedge clk);
                            if (cb_c == 4'd3 && td_c) found = 1'b1;
                        end
                        if (!found) begin
                            total++; bad++;
                            $display("FAIL c_wait_cb3 actual=timeout required=cb_bit 3");
                        end else begin
                            rst_c = 1'b1;
                            @(negedge clk);
                            chk("c_rst_dat", 32'(dat_c), 32'h0);
                            chk("c_rst_ok", 32'(ok_c), 32'h0);
                            chk("c_rst_flags", 32'({par_c, frm_c}), 32'h0);
                            chk("c_rst_start_cb", 32'({start_c, cb_c}), 32'h0);
                            chk("c_rst_t_flags", 32'({ts_c, td_c, tp_c, tst_c}), 32'h0);
                            repeat (8) @(negedge clk);
                            rst_c = 1'b0;
                        end
                    end
                join
                #(2 * BT);
                chk("c_no_ok_after_rst", 32'(dat_c), 32'h0);
                chk("c_idle_after_rst", 32'(start_c), 32'h0);
            end
        join

        repeat (10) @(negedge clk);
        chk("a_queue_empty", 32'(q_a.size()), 32'h0);
        chk("b_queue_empty", 32'(q_b.size()), 32'h0);
        chk("c_queue_empty", 32'(q_c.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/urxd_nb_rx.md
Name: urxd_nb_rx

Overview:
Parametrised successor to the single-byte UART receiver.
- Supported frame options: data width, parity mode, stop-bit count and oversampling rate.
- Start-bit validation and 3-sample majority vote per bit.
- Per-frame parity and framing error flags.
- Sits between the board RXD pin (or the loopback from the transmitter) and the byte consumer.
- Exposes the same debug strobes (ce_tact, ce_bit, T_* phase flags) for simulation and ChipScope.

Parameters:
F_CLK, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
NB, 8, data bits per frame (5..9)
PARITY, 0, 0 = none, 1 = even, 2 = odd
NSTOP, 1, stop bits checked (1 or 2)
OVS, 16, ce_tact ticks per bit (8 or 16)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
URXD  in  1  asynchronous serial line, idle high
en_rx  in  1  receive enable; low forces IDLE
rx_dat  out  NB  last received data word, LSB first on line
ok_rx_byte  out  1  one-clk pulse, rx_dat and error flags valid
err_par  out  1  parity mismatch on last frame
err_frame  out  1  stop bit sampled 0 on last frame
start_rx  out  1  frame in progress
cb_bit  out  4  bit index within current frame
ce_tact  out  1  oversample strobe
ce_bit  out  1  mid-bit sample strobe
T_start, T_dat, T_par, T_stop  out  1 each  current frame phase

Behaviour:
- Reset values:
  - rx_dat = 0.
  - All flags, strobes, start_rx and T_* = 0.
  - cb_bit = 0.
  - State = IDLE.
  - Synchroniser loaded with 1.
- Reset mid-frame aborts with no ok_rx_byte.
- Input synchroniser: 2-FF synchroniser on URXD, plus one more FF for falling-edge detect.
- Oversample tick generator:
  - DIV = round(F_CLK/(BAUD*OVS)), computed at elaboration; DIV = 27 at defaults.
  - ce_tact is a one-clk pulse every DIV clocks.
  - The prescaler and tick counter clear on start-edge detection to align sampling.
- Bit sampling: majority of 3 samples at ticks OVS/2-1, OVS/2 and OVS/2+1. ce_bit pulses on tick OVS/2+1.
- States:
  - IDLE: start_rx = 0. A falling edge with en_rx = 1 goes to START.
  - START: at ce_bit, voted value 1 means a false start and the FSM returns to IDLE with no flags. Voted value 0 goes to DATA with cb_bit = 0.
  - DATA: at each ce_bit, shift the voted bit in LSB-first and increment cb_bit. After NB bits, go to PAR if PARITY != 0, else STOP.
  - PAR: at ce_bit, compute err_par = XOR(data, bit) for even, inverted for odd. Go to STOP.
  - STOP: at each ce_bit, check the stop bit; err_frame is set if any checked stop bit is 0. After NSTOP bits:
    - rx_dat is loaded and err_par/err_frame are updated in the same clock.
    - ok_rx_byte pulses for exactly 1 clk on that clock.
    - The FSM returns to IDLE.
  - Return to IDLE happens at mid-stop-bit, so back-to-back frames are accepted.
- Output holding:
  - Error flags hold until the next ok_rx_byte.
  - rx_dat holds between frames and updates only at ok_rx_byte.
  - Frames with errors still pulse ok_rx_byte.
- T_* flags: exactly one is high while start_rx = 1, matching the state.
- Boundary cases:
  - en_rx falling mid-frame: IDLE next clk, no pulse, outputs unchanged.
  - Break (line held 0): err_frame = 1 with rx_dat = 0. IDLE is then not re-armed until the line has been seen high, which prevents a break from retriggering frames.
  - Edge coinciding with ok_rx_byte: the edge is honoured and START is entered on the next clk.
- Tolerance: correct reception up to ±3 % baud mismatch at OVS = 16.

Decomposition:
- Shared package uart_pkg holds:
  - Parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD.
  - State encoding constants.
  - A DIV computation function reused by the transmitter.
- Sub-module urxd_tick_gen: prescaler, with clear input and ce_tact output.
- The FSM and shift register stay in the top module.

Test Plan:
- Defaults, send 0x42 8N1 at 115200 from matching transmitter -> single ok_rx_byte, rx_dat = 0x42, err_par = 0, err_frame = 0, cb_bit reaches 8.
- PARITY = 1, send 0x42 with parity bit 1 (wrong; correct is 0) -> ok_rx_byte, rx_dat = 0x42, err_par = 1. Next frame 0x43 with parity 1 (correct) -> err_par = 0.
- Send 0xA5 with stop bit forced 0 -> ok_rx_byte, rx_dat = 0xA5, err_frame = 1. Hold line low 20 bit times -> no further ok_rx_byte until line returns high.
- 200 ns low glitch on idle line -> start_rx high briefly, returns to IDLE, no ok_rx_byte, flags unchanged.
- Transmitter clock period 20.6 ns and 19.4 ns (±3 %), 16 random bytes back-to-back -> all received correctly, one ok pulse each.
- NB = 7, PARITY = 2, NSTOP = 2: send 0x55 -> rx_dat = 0x55, no errors. Assert rst at cb_bit = 3 of next frame -> all outputs reset values, no ok_rx_byte.
